// File: rtl/pc_seq_pkg.sv
// Shared types and sizing helpers for the program sequencer and its return-address stack.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    OP_NEXT   = 3'd0,
    OP_BRANCH = 3'd1,
    OP_JUMP   = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4,
    OP_CLR    = 3'd5,
    OP_HALT   = 3'd6,
    OP_RSVD   = 3'd7
  } seq_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam int RAS_DEPTH_DEF = 4;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int RAS_PTR_W = ptr_w(RAS_DEPTH_DEF);

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Return-address stack: LIFO of DEPTH entries, top-of-stack visible combinationally on dout.
module ras_stack
  import pc_seq_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH_DEF,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = ptr_w(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W:0]   cnt;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] top_idx;
  logic             do_push;

  assign wr_idx  = cnt[PTR_W-1:0];
  assign top_idx = PTR_W'(cnt - 1'b1);
  assign full    = (cnt == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign dout    = mem[top_idx];
  assign do_push = push && !full && !clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (do_push)
      cnt <= cnt + 1'b1;
    else if (pop && !empty)
      cnt <= cnt - 1'b1;
  end

  // Entries above the count are never read, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_idx] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program sequencer: fetches over req/ack, holds PC/IR, and applies controller sequencing commands.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W      = 16,
  parameter int INST_W    = 16,
  parameter int OFF_W     = 8,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] ir,
  output logic              ir_valid,
  output logic [PC_W-1:0]   pc,
  input  logic              seq_en,
  input  logic [2:0]        seq_op,
  input  logic              cond,
  input  logic [OFF_W-1:0]  offset,
  input  logic [PC_W-1:0]   target,
  output logic              halted,
  output logic              ras_ovf,
  output logic              ras_unf
);

  // state | meaning
  // IDLE  | one cycle after reset before the first fetch
  // FETCH | imem_req held at pc until imem_ack
  // EXEC  | ir presented, waiting for a seq_en command
  // HALT  | stopped, only rst leaves

  state_e          state, state_nx;
  seq_op_e         op;
  logic [PC_W-1:0] iaddr;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] stk_dout;
  logic            fetch_done;
  logic            exec_cmd;
  logic            stk_push, stk_pop, stk_clr;
  logic            stk_full, stk_empty;

  assign op         = seq_op_e'(seq_op);
  assign br_target  = iaddr + PC_W'(signed'(offset));
  assign fetch_done = (state == ST_FETCH) && imem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  state_nx = ST_FETCH;
      ST_FETCH: if (imem_ack) state_nx = ST_EXEC;
      ST_EXEC:  if (seq_en) state_nx = (op == OP_HALT) ? ST_HALT : ST_FETCH;
      ST_HALT:  state_nx = ST_HALT;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state == ST_FETCH);
    imem_addr = pc;
    halted    = (state == ST_HALT);
    exec_cmd  = (state == ST_EXEC) && seq_en;
    stk_push  = exec_cmd && (op == OP_CALL);
    stk_pop   = exec_cmd && (op == OP_RET) && !stk_empty;
    stk_clr   = exec_cmd && (op == OP_CLR);
  end

  // In EXEC pc already holds iaddr+1, so NEXT and the reserved opcode need no action.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= '0;
      iaddr    <= '0;
      ir       <= '0;
      ir_valid <= 1'b0;
      ras_ovf  <= 1'b0;
      ras_unf  <= 1'b0;
    end else begin
      ir_valid <= fetch_done;
      if (fetch_done) begin
        ir    <= imem_data;
        iaddr <= pc;
        pc    <= pc + PC_W'(1);
      end
      if (exec_cmd) begin
        case (op)
          OP_BRANCH: if (cond) pc <= br_target;
          OP_JUMP:   pc <= target;
          OP_CALL: begin
            pc <= target;
            if (stk_full) ras_ovf <= 1'b1;
          end
          OP_RET: begin
            if (stk_empty) ras_unf <= 1'b1;
            else           pc <= stk_dout;
          end
          OP_CLR:    pc <= '0;
          default:   ;
        endcase
      end
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (stk_push),
    .pop   (stk_pop),
    .clr   (stk_clr),
    .din   (iaddr + PC_W'(1)),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset/fetch timing, a command vector table, and reset/halt corner sequences.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] ir;
  logic        ir_valid;
  logic [15:0] pc;
  logic        seq_en;
  logic [2:0]  seq_op;
  logic        cond;
  logic [7:0]  offset;
  logic [15:0] target;
  logic        halted;
  logic        ras_ovf;
  logic        ras_unf;

  int n_vec = 0;
  int n_err = 0;
  int wait_cycles = 0;
  int wcnt = 0;

  localparam logic [2:0] NEXT = 3'd0, BRANCH = 3'd1, JUMP = 3'd2, CALL = 3'd3,
                         RET = 3'd4, CLR = 3'd5, HALT = 3'd6, RSVD = 3'd7;

  typedef struct {
    logic [2:0]  op;
    logic        c;
    logic [7:0]  off;
    logic [15:0] tgt;
    logic [15:0] exp_addr;
    logic        exp_ovf;
    logic        exp_unf;
  } vec_t;

  vec_t tbl[22];

  pc_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .imem_addr (imem_addr),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .pc        (pc),
    .seq_en    (seq_en),
    .seq_op    (seq_op),
    .cond      (cond),
    .offset    (offset),
    .target    (target),
    .halted    (halted),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return (a == 16'h0000) ? 16'h1234 : (a ^ 16'h5A00);
  endfunction

  // Memory with wait_cycles wait states, driven on the falling edge.
  always @(negedge clk) begin
    if (imem_req && !rst) begin
      if (wcnt >= wait_cycles) begin
        imem_ack  = 1'b1;
        imem_data = mem_f(imem_addr);
      end else begin
        imem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wcnt     = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_ir();
    int n = 0;
    while (!ir_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ir_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL ir_valid_timeout: got 0 expected 1 within 50 cycles");
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic c, input logic [7:0] off,
                       input logic [15:0] tg);
    seq_en = 1'b1; seq_op = op; cond = c; offset = off; target = tg;
    @(negedge clk);
    seq_en = 1'b0;
  endtask

  initial begin
    logic [15:0] last_addr;
    int          req_cnt;
    int          addr_bad;

    tbl[0]  = '{JUMP,   1'b0, 8'h00, 16'h0010, 16'h0010, 1'b0, 1'b0};
    tbl[1]  = '{BRANCH, 1'b1, 8'hFE, 16'hDEAD, 16'h000E, 1'b0, 1'b0};
    tbl[2]  = '{JUMP,   1'b1, 8'h33, 16'h0010, 16'h0010, 1'b0, 1'b0};
    tbl[3]  = '{BRANCH, 1'b0, 8'hFE, 16'hDEAD, 16'h0011, 1'b0, 1'b0};
    tbl[4]  = '{BRANCH, 1'b1, 8'h05, 16'hDEAD, 16'h0016, 1'b0, 1'b0};
    tbl[5]  = '{CALL,   1'b0, 8'h00, 16'h0100, 16'h0100, 1'b0, 1'b0};
    tbl[6]  = '{CALL,   1'b1, 8'h7F, 16'h0200, 16'h0200, 1'b0, 1'b0};
    tbl[7]  = '{RET,    1'b0, 8'h00, 16'hDEAD, 16'h0101, 1'b0, 1'b0};
    tbl[8]  = '{RET,    1'b1, 8'h10, 16'hDEAD, 16'h0017, 1'b0, 1'b0};
    tbl[9]  = '{JUMP,   1'b0, 8'h00, 16'h0005, 16'h0005, 1'b0, 1'b0};
    tbl[10] = '{RET,    1'b0, 8'h00, 16'hDEAD, 16'h0006, 1'b0, 1'b1};
    tbl[11] = '{JUMP,   1'b0, 8'h00, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1};
    tbl[12] = '{NEXT,   1'b1, 8'h40, 16'hDEAD, 16'h0000, 1'b0, 1'b1};
    tbl[13] = '{RSVD,   1'b1, 8'h40, 16'hDEAD, 16'h0001, 1'b0, 1'b1};
    tbl[14] = '{CALL,   1'b0, 8'h00, 16'h0300, 16'h0300, 1'b0, 1'b1};
    tbl[15] = '{CALL,   1'b0, 8'h00, 16'h0310, 16'h0310, 1'b0, 1'b1};
    tbl[16] = '{CALL,   1'b0, 8'h00, 16'h0320, 16'h0320, 1'b0, 1'b1};
    tbl[17] = '{CALL,   1'b0, 8'h00, 16'h0330, 16'h0330, 1'b0, 1'b1};
    tbl[18] = '{CALL,   1'b0, 8'h00, 16'h0340, 16'h0340, 1'b1, 1'b1};
    tbl[19] = '{RET,    1'b0, 8'h00, 16'hDEAD, 16'h0321, 1'b1, 1'b1};
    tbl[20] = '{CLR,    1'b0, 8'h00, 16'hDEAD, 16'h0000, 1'b1, 1'b1};
    tbl[21] = '{RET,    1'b0, 8'h00, 16'hDEAD, 16'h0001, 1'b1, 1'b1};

    rst = 1'b1; seq_en = 1'b0; seq_op = 3'd0; cond = 1'b0; offset = '0; target = '0;
    imem_ack = 1'b0; imem_data = '0;

    // Reset values and first zero-wait fetch
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 16'h0);
    chk("rst_ir", ir, 16'h0);
    chk("rst_ir_valid", ir_valid, 1'b0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_flags", {ras_ovf, ras_unf}, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    chk("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 16'h0);
    @(negedge clk);
    chk("first_ir_valid", ir_valid, 1'b1);
    chk("first_ir", ir, 16'h1234);
    chk("first_pc", pc, 16'h0001);
    @(negedge clk);
    chk("ir_valid_pulse", ir_valid, 1'b0);
    chk("exec_no_req", imem_req, 1'b0);

    // Three wait states; seq_en during FETCH must be ignored
    wait_cycles = 3;
    issue(NEXT, 1'b0, 8'h00, 16'h0000);
    req_cnt = 0; addr_bad = 0;
    for (int i = 0; i < 50 && !ir_valid; i++) begin
      if (imem_req) begin
        req_cnt++;
        if (imem_addr !== 16'h0001) addr_bad++;
        seq_en = 1'b1; seq_op = JUMP; target = 16'h0777;
      end
      @(negedge clk);
    end
    seq_en = 1'b0;
    chk("wait3_req_cycles", req_cnt, 4);
    chk("wait3_addr_unstable", addr_bad, 0);
    chk("wait3_ir", ir, mem_f(16'h0001));
    chk("wait3_pc", pc, 16'h0002);
    wait_cycles = 0;

    // Command table
    last_addr = 16'h0001;
    foreach (tbl[i]) begin
      wait_ir();
      chk($sformatf("v%0d_ir", i), ir, mem_f(last_addr));
      issue(tbl[i].op, tbl[i].c, tbl[i].off, tbl[i].tgt);
      chk($sformatf("v%0d_req", i), imem_req, 1'b1);
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].exp_addr);
      chk($sformatf("v%0d_flags", i), {ras_ovf, ras_unf}, {tbl[i].exp_ovf, tbl[i].exp_unf});
      last_addr = tbl[i].exp_addr;
    end

    // Reset in the middle of a slow fetch
    wait_ir();
    wait_cycles = 5;
    issue(JUMP, 1'b0, 8'h00, 16'h0040);
    chk("mid_req", imem_req, 1'b1);
    chk("mid_addr", imem_addr, 16'h0040);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req", imem_req, 1'b0);
    chk("mid_rst_pc", pc, 16'h0);
    chk("mid_rst_ir", ir, 16'h0);
    chk("mid_rst_misc", {ir_valid, halted, ras_ovf, ras_unf}, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_cycles = 0;
    @(negedge clk);
    chk("post_rst_addr", imem_addr, 16'h0);
    wait_ir();
    chk("post_rst_ir", ir, 16'h1234);
    chk("post_rst_pc", pc, 16'h0001);

    // HALT: no requests and seq_en ignored for 20 cycles
    issue(HALT, 1'b0, 8'h00, 16'h0000);
    chk("halted", halted, 1'b1);
    req_cnt = 0;
    seq_en = 1'b1; seq_op = JUMP; target = 16'h0055;
    repeat (20) begin
      @(negedge clk);
      if (imem_req) req_cnt++;
    end
    seq_en = 1'b0;
    chk("halt_req_cycles", req_cnt, 0);
    chk("halt_still", halted, 1'b1);
    chk("halt_pc", pc, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program sequencer for the simple CPU: owns the program counter, the instruction register and a small return-address stack. It fetches from instruction memory over a req/ack handshake and presents the latched instruction to the controller FSM. It then waits for a sequencing command: next, conditional relative branch, absolute jump, call, return, clear or halt. It is the next-generation replacement for the fixed 16-bit PC/IR logic, adding wait-state memory, subroutine support and configurable widths.

## Interface
- PC_W, 16, program-counter / instruction-address width
- INST_W, 16, instruction width
- OFF_W, 8, signed branch-offset width (OFF_W ≤ PC_W)
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_addr  out  PC_W  fetch address (= pc while imem_req)
- imem_req  out  1  fetch request, held until imem_ack
- imem_ack  in  1  memory has imem_data valid this cycle
- imem_data  in  INST_W  fetched instruction
- ir  out  INST_W  instruction register
- ir_valid  out  1  one-cycle pulse: ir newly loaded
- pc  out  PC_W  current program counter
- seq_en  in  1  controller issues seq_op this cycle
- seq_op  in  3  command (seq_op_e)
- cond  in  1  branch condition (e.g. RF_Rp_zero)
- offset  in  OFF_W  signed branch offset
- target  in  PC_W  jump/call target
- halted  out  1  sequencer in HALT
- ras_ovf  out  1  sticky: push on full stack
- ras_unf  out  1  sticky: pop on empty stack

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- IDLE: entered on reset; unconditionally → FETCH next edge.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: ir←imem_data, iaddr←pc, pc←pc+1, → EXEC. Otherwise stay.
- EXEC: wait for seq_en. seq_en=0 → stay, no state change. On seq_en, act on seq_op, then → FETCH (except HALT):
  - NEXT (0): pc unchanged (already iaddr+1).
  - BRANCH (1): if cond, pc←iaddr+sext(offset); else unchanged.
  - JUMP (2): pc←target.
  - CALL (3): push iaddr+1; pc←target.
  - RET (4): pop into pc.
  - CLR (5): pc←0; stack emptied. Sticky flags are kept.
  - HALT (6): → HALT.
  - 7: treated as NEXT.
- HALT: no requests, ignores seq_en; exits only via rst.
- Arithmetic: all PC math is modulo 2^PC_W; wrap from all-ones to 0 is silent.
- CALL on full stack: push dropped, jump still taken, ras_ovf←1.
- RET on empty stack: pc unchanged (falls through), ras_unf←1.
- seq_en outside EXEC is ignored.

## Timing
- Reset values: pc=0, ir=0, ir_valid=0, imem_req=0, halted=0, ras_ovf=0, ras_unf=0, stack empty, state IDLE.
- imem_req rises on the first clk edge after rst deasserts.
- A same-cycle ack (zero-wait memory) completes the fetch in 1 cycle; each wait cycle adds 1.
- ir, pc and ir_valid update on the edge that samples imem_ack=1; ir_valid is high for exactly that following cycle.
- seq_en may be asserted in the same cycle as ir_valid. The command is applied on that edge, and FETCH of the new pc starts the next cycle.
- Minimum instruction period is 2 cycles (FETCH + EXEC).
- imem_req deasserts the cycle after the ack edge and must not glitch high in EXEC.
- imem_addr is stable while imem_req=1.
- rst mid-fetch: imem_req drops asynchronously and any ack in flight is discarded.

## Structure
- Package pc_seq_pkg: seq_op_e (NEXT, BRANCH, JUMP, CALL, RET, CLR, HALT), state_e, and the localparam for the pointer width, $clog2(RAS_DEPTH).
- Sub-module ras_stack: parameters DEPTH and W; ports push, pop, din, dout, clr, full, empty; asynchronous reset to empty. Push and pop never occur together.
- Top module: state FSM, pc/iaddr/ir registers and sticky flags; about 200 lines in total.

## Test plan
- Reset then zero-wait memory returning 0x1234 at addr 0 → imem_req rises 1 cycle after reset release; ir=0x1234 with a 1-cycle ir_valid pulse; pc=1.
- Ack delayed 3 cycles → imem_req held 4 cycles with imem_addr constant; pc increments once only.
- At iaddr=0x0010: BRANCH with offset=0xFE (−2) and cond=1 → next fetch at 0x000E. Same command with cond=0 → fetch at 0x0011.
- Nested CALLs to 0x0100, 0x0200, then RET, RET → fetches at 0x0100, 0x0200, return+1, and the first return+1. Five CALLs with RAS_DEPTH=4 → ras_ovf=1 and the fifth jump is still taken.
- RET on empty stack at iaddr=0x0005 → fetch at 0x0006 and ras_unf=1. JUMP to 0xFFFF then NEXT → fetch at 0x0000 (wrap).
- HALT → halted=1, no imem_req for 20 cycles. Assert rst mid-fetch → all outputs return to reset values immediately.
